ps2_key_receiver: RTL and testbench
===================================

Name: ps2_key_receiver

Overview:
Receives raw PS/2 keyboard traffic (device-to-host clock/data lines) and converts it into the single-cycle key-event interface consumed by vga_controller: an 8-bit scan code plus a one-cycle strobe. Contains a bit-level frame deserializer (sync, glitch filter, start/parity/stop checking, watchdog) and a scan-code layer that absorbs E0/F0 prefixes. Only make codes are reported. Runs entirely in the iVGA_CLK domain (25 MHz).

Parameters:
SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data before use
FILT_LEN, 8, consecutive identical synchronized ps2_clk samples required to accept a level change
TIMEOUT_CYC, 50000, iVGA_CLK cycles without a filtered falling edge mid-frame before the frame is abandoned (2 ms at 25 MHz)

Ports:
iVGA_CLK  input  1  system clock, all logic on its rising edge
iRST_n  input  1  asynchronous, active-low reset
ps2_clk  input  1  raw PS/2 clock from pad, asynchronous
ps2_data  input  1  raw PS/2 data from pad, asynchronous
key_in  output  8  last accepted make code; held until the next one
key_en  output  1  one-cycle strobe, high in the cycle key_in/key_ext update
key_ext  output  1  1 if the reported code was preceded by E0
frame_err  output  1  one-cycle pulse on parity, start, stop or timeout error

Behaviour:
- Reset (async assert, sync deassert through existing reset logic): key_in=0, key_en=0, key_ext=0, frame_err=0, FSM=IDLE, prefix flags cleared, filter state=1 (bus idle high).
- Sync: SYNC_STAGES flops per line. Filter: ps2_clk filtered level changes only after FILT_LEN equal samples. Falling edge of filtered clock = sample strobe; ps2_data (synchronized) sampled in that cycle.
- Frame FSM: IDLE -> (strobe, data=0) DATA; strobe with data=1 in IDLE -> frame_err, stay IDLE. DATA: shift 8 bits LSB first, bit counter 0..7, -> PARITY after 8th. PARITY: capture bit; odd parity over 8 data + parity required. -> STOP. STOP: data must be 1. Good frame -> byte_valid pulse, IDLE. Bad parity or stop -> frame_err pulse, byte discarded, IDLE.
- Watchdog: counter clears on every strobe and in IDLE; reaching TIMEOUT_CYC-1 in a non-IDLE state -> frame_err pulse, IDLE, partial byte discarded. Counter width ceil(log2(TIMEOUT_CYC)).
- Scan-code layer (acts on byte_valid, one cycle after STOP strobe):
  - E0: set ext flag, no output.
  - F0: set brk flag, no output.
  - Other byte with brk=1: clear brk and ext, no output.
  - Other byte with brk=0: key_in<=byte, key_ext<=ext, key_en=1 for exactly one cycle, clear ext.
- A frame error clears both prefix flags.
- Latency: key_en asserts 2 iVGA_CLK cycles after the filtered stop-bit falling edge.
- key_en never asserts on consecutive cycles; frame_err and key_en are mutually exclusive.
- Typematic repeats (same make with no break) are reported each time unless the optional feature is enabled.
- No host-to-device transmission; the block never drives ps2_clk/ps2_data.

Optional Feature:
PS2_REPEAT_FILT_EN: when defined, keeps last_make{ext,code} and a held flag. A make equal to last_make while held=1 is suppressed (no key_en). A break whose code and ext match last_make clears held. A different make is reported and replaces last_make. Reset clears held. When not defined, every make is reported and no tracking state exists.

Decomposition:
- Package ps2_pkg: localparams PS2_EXT=8'hE0, PS2_BRK=8'hF0; frame-FSM state encoding (IDLE, DATA, PARITY, STOP).
- Sub-module ps2_frame_rx: sync, filter, frame FSM, watchdog; outputs byte, byte_valid, frame_err.
- Top ps2_key_receiver: prefix/scan-code layer and the optional repeat filter.

Test Plan:
- Reset mid-frame: assert iRST_n=0 after 4 data bits -> all outputs 0, FSM IDLE; next clean frame 8'h1C gives key_in=1C, key_en single pulse.
- Left arrow E0 6B then E0 F0 6B -> exactly one key_en, key_in=6B, key_ext=1; break sequence produces no strobe.
- Frame 8'h74 with even parity -> frame_err one-cycle pulse, key_en stays 0, key_in unchanged.
- Stop clock after 5 bits -> frame_err at TIMEOUT_CYC cycles after the last edge; following frame 8'h72 is received correctly.
- 3-cycle glitch low on ps2_clk while idle with FILT_LEN=8 -> no strobe, no frame_err.
- Three consecutive 8'h74 makes -> 3 key_en pulses without PS2_REPEAT_FILT_EN; 1 with it; after F0 74 the next 74 is reported again.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared constants and types for the PS/2 keyboard receiver.
//   PS2_EXT / PS2_BRK : scan-code prefix bytes (extended key / break)
//   frame_state_t     : bit-level frame FSM states
//   oddParityOk()     : true when data + parity bit contain an odd number of 1s
// ---------------------------------------------------------------------------
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  function automatic logic oddParityOk(input logic [7:0] i_data, input logic i_par);
    return ^{i_data, i_par};
  endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// ---------------------------------------------------------------------------
// ps2_key_receiver_if
// Key-event bus between the PS/2 receiver and its consumer (vga_controller).
//   key_in    : last accepted make code, held until the next one
//   key_en    : one-cycle strobe when key_in/key_ext update
//   key_ext   : reported code was preceded by E0
//   frame_err : one-cycle pulse on a rejected or abandoned frame
// Modports: master = receiver (drives), slave = consumer (reads).
// ---------------------------------------------------------------------------
interface ps2_key_receiver_if;

  logic [7:0] key_in;
  logic       key_en;
  logic       key_ext;
  logic       frame_err;

  modport master (
    output key_in,
    output key_en,
    output key_ext,
    output frame_err
  );

  modport slave (
    input key_in,
    input key_en,
    input key_ext,
    input frame_err
  );

endinterface

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// Bit-level PS/2 device-to-host frame deserializer.
//   Synchronizes the raw clock/data pads, glitch-filters the clock, samples
//   data on each filtered falling edge and checks start/parity/stop bits.
//   A watchdog abandons a frame that stalls mid-way.
// Ports:
//   iVGA_CLK      : system clock (rising edge)
//   iRST_n        : asynchronous active-low reset
//   i_ps2Clk      : raw PS/2 clock pad (asynchronous)
//   i_ps2Data     : raw PS/2 data pad (asynchronous)
//   o_byte        : received byte (valid while o_byteValid is high)
//   o_byteValid   : one-cycle pulse for a good frame
//   o_frameErr    : one-cycle pulse on start/parity/stop/timeout error
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       i_ps2Clk,
  input  logic       i_ps2Data,
  output logic [7:0] o_byte,
  output logic       o_byteValid,
  output logic       o_frameErr
);

  localparam int FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [SYNC_STAGES-1:0] r_clkSync;
  logic [SYNC_STAGES-1:0] r_dataSync;
  logic                   w_clkS;
  logic                   w_dataS;

  logic                   r_clkFilt;
  logic [FILT_W-1:0]      r_filtCnt;
  logic                   r_strobe;

  frame_state_t           r_state;
  logic [7:0]             r_shift;
  logic [2:0]             r_bitCnt;
  logic                   r_parity;
  logic [WD_W-1:0]        r_wdCnt;
  logic                   r_byteValid;
  logic                   r_frameErr;

  assign w_clkS  = r_clkSync[SYNC_STAGES-1];
  assign w_dataS = r_dataSync[SYNC_STAGES-1];

  // Synchronizer chains; both lines idle high, so reset to 1 to avoid a
  // spurious falling edge right after reset.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_clkSync  <= '1;
      r_dataSync <= '1;
    end else begin
      r_clkSync  <= {r_clkSync[SYNC_STAGES-2:0], i_ps2Clk};
      r_dataSync <= {r_dataSync[SYNC_STAGES-2:0], i_ps2Data};
    end
  end

  // Clock glitch filter: the filtered level only follows the synchronized
  // clock after FILT_LEN consecutive samples that differ from it. Any sample
  // that agrees with the current level restarts the count. A 1->0 update
  // raises the sample strobe for the following cycle.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_clkFilt <= 1'b1;
      r_filtCnt <= '0;
      r_strobe  <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (w_clkS == r_clkFilt) begin
        r_filtCnt <= '0;
      end else if (r_filtCnt == FILT_W'(FILT_LEN - 1)) begin
        r_clkFilt <= w_clkS;
        r_filtCnt <= '0;
        r_strobe  <= r_clkFilt;
      end else begin
        r_filtCnt <= r_filtCnt + 1'b1;
      end
    end
  end

  // Frame FSM with watchdog. Bits arrive LSB first; the parity bit is kept
  // and checked together with the stop bit so a bad frame yields a single
  // error pulse at the end. The watchdog only runs while a frame is open and
  // restarts on every strobe; on expiry the partial byte is dropped.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bitCnt    <= '0;
      r_parity    <= 1'b0;
      r_wdCnt     <= '0;
      r_byteValid <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_byteValid <= 1'b0;
      r_frameErr  <= 1'b0;

      if ((r_state == IDLE) || r_strobe) begin
        r_wdCnt <= '0;
      end else begin
        r_wdCnt <= r_wdCnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (r_strobe) begin
            if (!w_dataS) begin
              r_state  <= DATA;
              r_bitCnt <= '0;
            end else begin
              r_frameErr <= 1'b1;
            end
          end
        end
        DATA: begin
          if (r_strobe) begin
            r_shift  <= {w_dataS, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt == 3'd7) begin
              r_state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (r_strobe) begin
            r_parity <= w_dataS;
            r_state  <= STOP;
          end
        end
        STOP: begin
          if (r_strobe) begin
            if (w_dataS && oddParityOk(r_shift, r_parity)) begin
              r_byteValid <= 1'b1;
            end else begin
              r_frameErr <= 1'b1;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if ((r_state != IDLE) && !r_strobe && (r_wdCnt == WD_W'(TIMEOUT_CYC - 1))) begin
        r_state    <= IDLE;
        r_frameErr <= 1'b1;
      end
    end
  end

  assign o_byte      = r_shift;
  assign o_byteValid = r_byteValid;
  assign o_frameErr  = r_frameErr;

endmodule

// File: rtl/ps2_key_receiver.sv
// ---------------------------------------------------------------------------
// ps2_key_receiver
// PS/2 keyboard receiver producing single-cycle key events for vga_controller.
// Only make codes are reported; E0 (extended) and F0 (break) prefixes are
// absorbed, and a break code is swallowed together with its prefixes.
// Ports:
//   iVGA_CLK  : 25 MHz system clock (rising edge)
//   iRST_n    : asynchronous active-low reset
//   ps2_clk   : raw PS/2 clock pad (input only, never driven)
//   ps2_data  : raw PS/2 data pad (input only, never driven)
//   keyBus    : key event bus (key_in, key_en, key_ext, frame_err), master
// Optional build macro PS2_REPEAT_FILT_EN: suppresses typematic repeats of
// the last make code until its matching break has been seen.
// ---------------------------------------------------------------------------
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_key_receiver_if.master keyBus
);

  logic [7:0] w_byte;
  logic       w_byteValid;
  logic       w_frameErr;

  logic [7:0] r_keyIn;
  logic       r_keyEn;
  logic       r_keyExt;
  logic       r_extFlag;
  logic       r_brkFlag;

`ifdef PS2_REPEAT_FILT_EN
  logic [8:0] r_lastMake;
  logic       r_held;
`endif

  ps2_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frameRx (
    .iVGA_CLK    (iVGA_CLK),
    .iRST_n      (iRST_n),
    .i_ps2Clk    (ps2_clk),
    .i_ps2Data   (ps2_data),
    .o_byte      (w_byte),
    .o_byteValid (w_byteValid),
    .o_frameErr  (w_frameErr)
  );

  // Scan-code layer. Prefixes only set flags; a code following F0 is a
  // break and just clears the flags; any other code is a make and is
  // reported with the pending E0 flag. A frame error means the prefix
  // context can no longer be trusted, so both flags are dropped.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_keyIn   <= '0;
      r_keyEn   <= 1'b0;
      r_keyExt  <= 1'b0;
      r_extFlag <= 1'b0;
      r_brkFlag <= 1'b0;
`ifdef PS2_REPEAT_FILT_EN
      r_lastMake <= '0;
      r_held     <= 1'b0;
`endif
    end else begin
      r_keyEn <= 1'b0;
      if (w_frameErr) begin
        r_extFlag <= 1'b0;
        r_brkFlag <= 1'b0;
      end else if (w_byteValid) begin
        if (w_byte == PS2_EXT) begin
          r_extFlag <= 1'b1;
        end else if (w_byte == PS2_BRK) begin
          r_brkFlag <= 1'b1;
        end else if (r_brkFlag) begin
          r_brkFlag <= 1'b0;
          r_extFlag <= 1'b0;
`ifdef PS2_REPEAT_FILT_EN
          // Releasing the held key re-arms reporting of that code.
          if ({r_extFlag, w_byte} == r_lastMake) begin
            r_held <= 1'b0;
          end
`endif
        end else begin
          r_extFlag <= 1'b0;
`ifdef PS2_REPEAT_FILT_EN
          // A repeat of the held key is dropped; anything else is reported
          // and becomes the new held key.
          if (!(r_held && ({r_extFlag, w_byte} == r_lastMake))) begin
            r_keyIn    <= w_byte;
            r_keyExt   <= r_extFlag;
            r_keyEn    <= 1'b1;
            r_lastMake <= {r_extFlag, w_byte};
          end
          r_held <= 1'b1;
`else
          r_keyIn  <= w_byte;
          r_keyExt <= r_extFlag;
          r_keyEn  <= 1'b1;
`endif
        end
      end
    end
  end

  assign keyBus.key_in    = r_keyIn;
  assign keyBus.key_en    = r_keyEn;
  assign keyBus.key_ext   = r_keyExt;
  assign keyBus.frame_err = w_frameErr;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_receiver
// Self-checking bench for ps2_key_receiver. A PS/2 device model drives
// frames (40 system clocks per bit); a monitor records every key event and
// error pulse; expected key events are queued when frames are sent and
// matched against the recorded ones.
// ---------------------------------------------------------------------------
module tb_ps2_key_receiver;

  localparam int TIMEOUT_CYC = 50000;

  logic clk    = 1'b0;
  logic rstN   = 1'b0;
  logic ps2Clk = 1'b1;
  logic ps2Dat = 1'b1;

  ps2_key_receiver_if keyBus();

  ps2_key_receiver #(
    .SYNC_STAGES (2),
    .FILT_LEN    (8),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .iVGA_CLK (clk),
    .iRST_n   (rstN),
    .ps2_clk  (ps2Clk),
    .ps2_data (ps2Dat),
    .keyBus   (keyBus)
  );

  always #20 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
  } keyEvt_t;

  typedef struct {
    logic [7:0] code;
    bit         badPar;
    bit         expKey;
    logic [7:0] expCode;
    bit         expExt;
    bit         expErr;
  } vec_t;

  keyEvt_t expQ[$];
  keyEvt_t obsQ[$];

  int testsRun    = 0;
  int testsFailed = 0;
  int enCount     = 0;
  int errCount    = 0;
  bit violation   = 1'b0;
  bit prevEn      = 1'b0;
  bit prevErr     = 1'b0;

  logic [7:0] expKeyIn  = 8'h00;
  logic       expKeyExt = 1'b0;

  // Monitor: record key events, count error pulses, flag protocol breaks
  // (back-to-back strobes, multi-cycle errors, strobe together with error).
  always @(negedge clk) begin
    if (keyBus.key_en) begin
      obsQ.push_back(keyEvt_t'{keyBus.key_in, keyBus.key_ext});
      enCount++;
    end
    if (keyBus.frame_err) errCount++;
    if ((keyBus.key_en && prevEn) || (keyBus.frame_err && prevErr) ||
        (keyBus.key_en && keyBus.frame_err)) violation = 1'b1;
    prevEn  = keyBus.key_en;
    prevErr = keyBus.frame_err;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic ps2Bit(input logic b);
    ps2Dat = b;
    repeat (10) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit badPar, input bit badStop);
    logic par;
    par = ~^b;
    if (badPar) par = ~par;
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(b[i]);
    ps2Bit(par);
    ps2Bit(badStop ? 1'b0 : 1'b1);
    ps2Dat = 1'b1;
  endtask

  task automatic sendMake(input logic [7:0] b, input bit expected, input bit ext);
    if (expected) expQ.push_back(keyEvt_t'{b, ext});
    sendFrame(b, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.expKey) expQ.push_back(keyEvt_t'{v.expCode, v.expExt});
    sendFrame(v.code, v.badPar, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  task automatic checkScoreboard(input string tag);
    keyEvt_t e;
    keyEvt_t o;
    checkOutput({tag, "_event_count"}, obsQ.size(), expQ.size());
    while (expQ.size() > 0 && obsQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      checkOutput({tag, "_code"}, o.code, e.code);
      checkOutput({tag, "_ext"}, o.ext, e.ext);
    end
    expQ.delete();
    obsQ.delete();
  endtask

  vec_t vecs[14];

  initial begin
    int enBase;
    int errBase;
    int cyc;
    bit seen;
    int expRepeat;

    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0};
    vecs[1]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{8'h6B, 1'b0, 1'b1, 8'h6B, 1'b1, 1'b0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{8'h6B, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{8'h74, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0};
    vecs[8]  = '{8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{8'h74, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[10] = '{8'h29, 1'b0, 1'b1, 8'h29, 1'b0, 1'b0};
    vecs[11] = '{8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{8'h29, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_key_in", keyBus.key_in, 8'h00);
    checkOutput("reset_key_en", keyBus.key_en, 1'b0);
    checkOutput("reset_key_ext", keyBus.key_ext, 1'b0);
    checkOutput("reset_frame_err", keyBus.frame_err, 1'b0);
    rstN = 1'b1;
    repeat (20) @(negedge clk);

    // Table-driven frames: prefixes, breaks, parity errors
    for (int i = 0; i < 14; i++) begin
      enBase  = enCount;
      errBase = errCount;
      applyStimulus(vecs[i]);
      if (vecs[i].expKey) begin
        expKeyIn  = vecs[i].expCode;
        expKeyExt = vecs[i].expExt;
      end
      checkOutput($sformatf("row%0d_en_pulses", i), enCount - enBase, {31'd0, vecs[i].expKey});
      checkOutput($sformatf("row%0d_err_pulses", i), errCount - errBase, {31'd0, vecs[i].expErr});
      checkOutput($sformatf("row%0d_key_in", i), keyBus.key_in, expKeyIn);
      checkOutput($sformatf("row%0d_key_ext", i), keyBus.key_ext, expKeyExt);
    end
    checkScoreboard("table");

    // Latency: key_en 2 cycles after filtered stop edge = 12 cycles after raw edge
    expQ.push_back(keyEvt_t'{8'h15, 1'b0});
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(i == 0 || i == 2 || i == 4);
    ps2Bit(1'b0);
    ps2Dat = 1'b1;
    repeat (10) @(negedge clk);
    ps2Clk = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (keyBus.key_en) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    checkOutput("latency_seen", seen, 1'b1);
    checkOutput("latency_window", (cyc >= 11 && cyc <= 13), 1'b1);
    @(negedge clk);
    repeat (20) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (20) @(negedge clk);
    checkScoreboard("latency");

    // Short glitch on idle clock is filtered; a long low pulse with data high
    // is a real strobe without a start bit and must raise frame_err.
    enBase  = enCount;
    errBase = errCount;
    ps2Clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("glitch_no_err", errCount - errBase, 0);
    checkOutput("glitch_no_key", enCount - enBase, 0);
    ps2Clk = 1'b0;
    repeat (15) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("idle_strobe_data1_err", errCount - errBase, 1);

    // Watchdog: stall after start + 5 data bits
    errBase = errCount;
    enBase  = enCount;
    ps2Bit(1'b0);
    for (int i = 0; i < 5; i++) ps2Bit(1'b1);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 1; i <= TIMEOUT_CYC + 1000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (keyBus.frame_err) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    checkOutput("timeout_seen", seen, 1'b1);
    checkOutput("timeout_window", (cyc >= TIMEOUT_CYC - 22 && cyc <= TIMEOUT_CYC - 16), 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("timeout_err_pulses", errCount - errBase, 1);
    checkOutput("timeout_no_key", enCount - enBase, 0);
    sendMake(8'h72, 1'b1, 1'b0);
    checkOutput("after_timeout_key_in", keyBus.key_in, 8'h72);
    checkScoreboard("timeout");

    // Reset in the middle of a frame
    ps2Bit(1'b0);
    for (int i = 0; i < 4; i++) ps2Bit(i[0]);
    rstN = 1'b0;
    #5;
    checkOutput("midreset_key_in", keyBus.key_in, 8'h00);
    checkOutput("midreset_key_en", keyBus.key_en, 1'b0);
    checkOutput("midreset_key_ext", keyBus.key_ext, 1'b0);
    checkOutput("midreset_frame_err", keyBus.frame_err, 1'b0);
    ps2Dat = 1'b1;
    repeat (5) @(negedge clk);
    rstN = 1'b1;
    repeat (20) @(negedge clk);
    enBase  = enCount;
    errBase = errCount;
    sendMake(8'h1C, 1'b1, 1'b0);
    checkOutput("midreset_next_key_in", keyBus.key_in, 8'h1C);
    checkOutput("midreset_next_pulses", enCount - enBase, 1);
    checkOutput("midreset_next_no_err", errCount - errBase, 0);
    checkScoreboard("midreset");

    // Typematic repeats, then break and make again
`ifdef PS2_REPEAT_FILT_EN
    expRepeat = 1;
`else
    expRepeat = 3;
`endif
    enBase = enCount;
    for (int i = 0; i < 3; i++) sendMake(8'h74, (i < expRepeat), 1'b0);
    checkOutput("repeat_pulses", enCount - enBase, expRepeat);
    enBase = enCount;
    sendMake(8'hF0, 1'b0, 1'b0);
    sendMake(8'h74, 1'b0, 1'b0);
    sendMake(8'h74, 1'b1, 1'b0);
    checkOutput("after_break_pulses", enCount - enBase, 1);
    checkOutput("after_break_key_in", keyBus.key_in, 8'h74);
    checkScoreboard("repeat");

    checkOutput("protocol_violation", violation, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
